layer1_sequencer: RTL and testbench

Sequences the hidden-layer computation of the ternary network: for each hidden neuron it walks the input bits, accumulates ternary weight contributions, adds the neuron bias with saturation, applies the sign activation, and stores the ±1 result in a packed hidden-activation register. It sits between the input capture logic and the output layer. It owns the addressing of the weight and bias stores and presents a start/busy/done handshake to the top-level controller.

---
 rtl/layer1_sequencer_pkg.sv | 28 ++
 rtl/layer1_sequencer_sign_activation.sv | 14 +
 rtl/layer1_sequencer.sv | 159 +++++++++++++++
 tb/tb_layer1_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer1_sequencer_pkg.sv
// Shared types and arithmetic helpers for the hidden-layer sequencer.
// Holds the FSM state enum, ternary weight/activation codes and saturation.
package layer1_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [1:0] PLUS1   = 2'b01;
  localparam logic [1:0] MINUS1  = 2'b11;
  localparam logic [1:0] ZERO    = 2'b00;
  localparam logic [1:0] ILLEGAL = 2'b10;

  // Clamp v into the signed range of a w-bit value.
  function automatic int sat(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/layer1_sequencer_sign_activation.sv
// Sign activation: maps a signed pre-activation to a ternary code.
// Non-negative values (including zero) give +1, negative values give -1.
module sign_activation
  import layer1_sequencer_pkg::*;
#(
  parameter int W = 7
) (
  input  logic signed [W-1:0] s,
  output logic        [1:0]   act
);

  assign act = s[W-1] ? MINUS1 : PLUS1;

endmodule

// File: rtl/layer1_sequencer.sv
// Hidden-layer sequencer: walks inputs per neuron, accumulates ternary weights,
// adds a saturated bias and stores the sign activation into a packed register.
module layer1_sequencer
  import layer1_sequencer_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_HID = 4,
  parameter int ACC_W = 7,
  localparam int WA_W = (N_IN * N_HID > 1) ? $clog2(N_IN * N_HID) : 1,
  localparam int BA_W = (N_HID > 1) ? $clog2(N_HID) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_IN-1:0]         x_in,
  output logic [WA_W-1:0]         w_addr,
  input  logic [1:0]              w_data,
  output logic [BA_W-1:0]         b_addr,
  input  logic signed [ACC_W-1:0] b_data,
  output logic                    busy,
  output logic                    done,
  output logic [2*N_HID-1:0]      hidden,
  output logic                    hidden_valid,
  output seq_state_e              state_dbg
);

  // Handshake: start is a single-cycle request honoured only while IDLE; busy
  // covers ACCUM/BIAS/DONE; done pulses for the DONE cycle, and hidden_valid
  // rises with done and stays high until the next accepted start or reset.

  localparam int J_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  seq_state_e              state_q, state_d;
  logic [N_IN-1:0]         x_q;
  logic [BA_W-1:0]         i_q;
  logic [J_W-1:0]          j_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [2*N_HID-1:0]      hidden_q;
  logic                    hv_q;
  logic [WA_W-1:0]         w_addr_q;
  logic [BA_W-1:0]         b_addr_q;
  logic [WA_W-1:0]         wa_cur;

  logic                    last_j;
  logic                    last_i;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W:0]   bias_sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [ACC_W-1:0] bias_sat;
  logic [1:0]              act;

  assign last_j = (j_q == J_W'(N_IN - 1));
  assign last_i = (i_q == BA_W'(N_HID - 1));
  assign wa_cur = WA_W'(int'(i_q) * N_IN + int'(j_q));

  // Illegal weight code 10 and inactive inputs both contribute nothing.
  always_comb begin
    term = '0;
    if (x_q[j_q] && (w_data != ILLEGAL)) begin
      term = {{(ACC_W-2){w_data[1]}}, w_data};
    end
  end

  // Sums carry one guard bit so saturation sees the true result.
  assign acc_sum  = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
  assign bias_sum = {acc_q[ACC_W-1], acc_q} + {b_data[ACC_W-1], b_data};
  assign acc_sat  = ACC_W'(sat(int'(acc_sum), ACC_W));
  assign bias_sat = ACC_W'(sat(int'(bias_sum), ACC_W));

  sign_activation #(
    .W (ACC_W)
  ) u_sign (
    .s   (bias_sat),
    .act (act)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last_j) state_d = BIAS;
      BIAS:    state_d = last_i ? DONE : ACCUM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM register, counters, captured inputs and the activation register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      hidden_q <= '0;
      hv_q     <= 1'b0;
      w_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q  <= x_in;
            i_q  <= '0;
            j_q  <= '0;
            hv_q <= 1'b0;
          end
        end
        ACCUM: begin
          w_addr_q <= wa_cur;
          if (!last_j) j_q <= j_q + 1'b1;
        end
        BIAS: begin
          b_addr_q <= i_q;
          for (int n = 0; n < N_HID; n++) begin
            if (i_q == BA_W'(n)) hidden_q[2*n +: 2] <= act;
          end
          // Valid is raised on entry to DONE so it coincides with the done pulse.
          if (last_i) begin
            hv_q <= 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
            j_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (start) acc_q <= '0;
        ACCUM:   acc_q <= acc_sat;
        BIAS:    if (!last_i) acc_q <= '0;
        default: ;
      endcase
    end
  end

  // Addresses hold their last driven value outside their active state.
  assign w_addr       = (state_q == ACCUM) ? wa_cur : w_addr_q;
  assign b_addr       = (state_q == BIAS) ? i_q : b_addr_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign hidden       = hidden_q;
  assign hidden_valid = hv_q;
  assign state_dbg    = state_q;

  a_done_valid : assert property (@(posedge clk) disable iff (!rst_n) done |-> hidden_valid);
  a_done_busy  : assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

// File: tb/tb_layer1_sequencer.sv
// Bench for layer1_sequencer: spec-derived vector table, hand-built handshake
// and reset sequences, and randomized runs checked against a behavioural model.
module tb_layer1_sequencer;
  import layer1_sequencer_pkg::*;

  localparam int N_IN  = 8;
  localparam int N_HID = 4;
  localparam int ACC_W = 7;
  localparam int LAT   = N_HID * (N_IN + 1);

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [N_IN-1:0]         x_in;
  logic [4:0]              w_addr;
  logic [1:0]              w_data;
  logic [1:0]              b_addr;
  logic signed [ACC_W-1:0] b_data;
  logic                    busy;
  logic                    done;
  logic [2*N_HID-1:0]      hidden;
  logic                    hidden_valid;
  seq_state_e              state_dbg;

  logic [1:0]              w_mem [N_IN*N_HID];
  logic signed [ACC_W-1:0] b_mem [N_HID];

  assign w_data = w_mem[w_addr];
  assign b_data = b_mem[b_addr];

  layer1_sequencer #(
    .N_IN  (N_IN),
    .N_HID (N_HID),
    .ACC_W (ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .x_in         (x_in),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .busy         (busy),
    .done         (done),
    .hidden       (hidden),
    .hidden_valid (hidden_valid),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2*N_HID-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per neuron, sum +1/-1 for each set input, clamp every
  // step to the signed range, add bias with clamping, take the sign.
  function automatic int clamp(input int v);
    if (v > 63) return 63;
    if (v < -64) return -64;
    return v;
  endfunction

  function automatic logic [2*N_HID-1:0] model_hidden(input logic [N_IN-1:0] x);
    logic [2*N_HID-1:0] r;
    int acc;
    int s;
    int t;
    r = '0;
    for (int n = 0; n < N_HID; n++) begin
      acc = 0;
      for (int j = 0; j < N_IN; j++) begin
        t = 0;
        if (x[j]) begin
          if (w_mem[n*N_IN + j] == 2'b01) t = 1;
          else if (w_mem[n*N_IN + j] == 2'b11) t = -1;
        end
        acc = clamp(acc + t);
      end
      s = clamp(acc + int'(b_mem[n]));
      r[2*n +: 2] = (s >= 0) ? 2'b01 : 2'b11;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [N_IN-1:0]                x;
    logic [N_HID-1:0][1:0]          w;
    logic [N_HID-1:0][ACC_W-1:0]    b;
    logic [2*N_HID-1:0]             exp;
  } vec_t;

  vec_t vecs[4];

  task automatic load_vec(input vec_t v);
    for (int n = 0; n < N_HID; n++) begin
      for (int j = 0; j < N_IN; j++) w_mem[n*N_IN + j] = v.w[n];
      b_mem[n] = $signed(v.b[n]);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hidden", hidden, 0);
    check("rst_hvalid", hidden_valid, 0);
    check("rst_waddr", w_addr, 0);
    check("rst_baddr", b_addr, 0);
    check("rst_state", state_dbg, IDLE);
  endtask

  task automatic launch(input logic [N_IN-1:0] x);
    exp_q.push_back(model_hidden(x));
    @(negedge clk);
    x_in  = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_hvclr", hidden_valid, 0);
  endtask

  task automatic finish(input int pulse_at, input int toggle_at, input bit chain,
                        input logic [N_IN-1:0] chain_x);
    int cyc;
    int busy_drop;
    logic [2*N_HID-1:0] exp;
    cyc = 0;
    busy_drop = 0;
    while (done !== 1'b1 && cyc < LAT + 20) begin
      if (busy !== 1'b1) busy_drop++;
      start = (cyc == pulse_at);
      if (cyc == toggle_at) x_in = ~x_in;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, LAT);
    check("busy_hold", busy_drop, 0);
    check("done_hvalid", hidden_valid, 1);
    check("done_busy", busy, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("hidden", hidden, exp);
    if (chain) begin
      // start during DONE (ignored) held into the IDLE cycle (accepted)
      start = 1'b1;
      x_in  = chain_x;
      exp_q.push_back(model_hidden(chain_x));
      @(negedge clk);
      check("chain_idle_done", done, 0);
      check("chain_idle_busy", busy, 0);
      check("chain_idle_hv", hidden_valid, 1);
      @(negedge clk);
      start = 1'b0;
      check("chain_busy", busy, 1);
      check("chain_hvdrop", hidden_valid, 0);
    end else begin
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("hv_hold", hidden_valid, 1);
      check("hidden_hold", hidden, exp);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N_IN-1:0] x;
    int seen;

    vecs[0] = '{x: 8'hFF, w: {4{2'b01}}, b: {4{7'h7D}}, exp: 8'h55};
    vecs[1] = '{x: 8'h0F, w: {4{2'b01}}, b: {4{7'h7C}}, exp: 8'h55};
    vecs[2] = '{x: 8'hFF, w: {2'b01, 2'b11, 2'b01, 2'b01}, b: {4{7'h00}}, exp: 8'h75};
    vecs[3] = '{x: 8'hFF, w: {2'b11, 2'b01, 2'b11, 2'b01},
                b: {7'h40, 7'h3F, 7'h40, 7'h3F}, exp: 8'hDD};

    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    for (int k = 0; k < N_IN*N_HID; k++) w_mem[k] = 2'b00;
    for (int n = 0; n < N_HID; n++) b_mem[n] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // table-driven spec vectors
    for (int v = 0; v < 4; v++) begin
      load_vec(vecs[v]);
      launch(vecs[v].x);
      finish(-1, -1, 1'b0, '0);
      check("table_exp", hidden, vecs[v].exp);
    end

    // illegal code 10 contributes nothing: 7 ones + 0 with bias -7 -> 0 -> +1
    load_vec(vecs[2]);
    w_mem[0] = 2'b10;
    b_mem[0] = -7;
    launch(8'hFF);
    finish(-1, -1, 1'b0, '0);
    check("illegal_pos", hidden, 8'h75);
    b_mem[0] = -8;
    launch(8'hFF);
    finish(-1, -1, 1'b0, '0);
    check("illegal_neg", hidden, 8'h77);

    // mid-run start pulse and x_in toggle are ignored
    for (int k = 0; k < N_IN*N_HID; k++) w_mem[k] = 2'($urandom_range(0, 3));
    for (int n = 0; n < N_HID; n++) b_mem[n] = 7'($urandom_range(0, 15)) - 7'sd8;
    launch(8'hA5);
    finish(10, 5, 1'b0, '0);

    // back-to-back: start in DONE ignored, in following IDLE accepted
    launch(8'h3C);
    finish(-1, -1, 1'b1, 8'hC3);
    finish(-1, -1, 1'b0, '0);

    // reset mid-run discards the run and prior result
    launch(8'hFF);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    seen = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("no_done_after_rst", seen, 0);
    load_vec(vecs[0]);
    launch(vecs[0].x);
    finish(-1, -1, 1'b0, '0);

    // randomized runs against the model
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < N_IN*N_HID; k++) w_mem[k] = 2'($urandom_range(0, 3));
      for (int n = 0; n < N_HID; n++) b_mem[n] = 7'($urandom_range(0, 127));
      x = 8'($urandom);
      launch(x);
      finish(-1, -1, 1'b0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
